lfsr_gen: RTL and testbench

Parametrised Fibonacci XNOR LFSR random-word source with a seed-load port, a valid/ready output stream, and an optional multi-step advance per cycle. It generalises the 16-bit fixed-tap LFSR to any width up to 64 bits and any tap mask. It feeds test-pattern and dither consumers, delivering one word per accepted transfer or advancing every cycle in free-run mode. It adds lockup protection against the all-ones XNOR dead state and an accepted-word counter.

---
 rtl/lfsr_pkg.sv | 7 +
 rtl/lfsr_step_n.sv | 16 +
 rtl/lfsr_gen.sv | 49 ++++
 tb/tb_lfsr_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: tap constants and FSM state type shared by the LFSR generator
package lfsr_pkg;
  localparam logic [15:0] TAPS16 = 16'hD008;
  localparam logic [31:0] TAPS32 = 32'h8020_0003;
  localparam logic [63:0] TAPS64 = 64'hD800_0000_0000_0000;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/lfsr_step_n.sv
// lfsr_step_n: STEPS unrolled Fibonacci XNOR shifts in one combinational stage
module lfsr_step_n #(
  parameter int WIDTH = 64,
  parameter logic [WIDTH-1:0] TAPS = lfsr_pkg::TAPS64[WIDTH-1:0],
  parameter int STEPS = 1
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);
  logic [WIDTH-1:0] s [STEPS+1];
  assign s[0] = cur;
  for (genvar i = 0; i < STEPS; i++) begin : g_step
    assign s[i+1] = {s[i][WIDTH-2:0], ~^(s[i] & TAPS)};
  end
  assign nxt = s[STEPS];
endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: seedable XNOR LFSR word source with valid/ready stream, free-run and lockup-safe load
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter logic [WIDTH-1:0] TAPS = lfsr_pkg::TAPS64[WIDTH-1:0],
  parameter int STEPS = 1,
  parameter logic [WIDTH-1:0] RESET_SEED = '0,
  parameter logic [WIDTH-1:0] SAFE_SEED = '0,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             load_i,
  input  logic             free_run_i,
  output logic [WIDTH-1:0] rnd_o,
  output logic             rnd_valid_o,
  input  logic             rnd_ready_i,
  output logic             seed_fix_o,
  output logic [CNT_W-1:0] word_cnt_o
);
  state_t fsm;
  logic [WIDTH-1:0] nxt;
  logic ones;
  assign ones = &seed_i;
  lfsr_step_n #(.WIDTH(WIDTH), .TAPS(TAPS), .STEPS(STEPS)) u_step (.cur(rnd_o), .nxt(nxt));
  // all-ones is the XNOR dead state, so a seed of all ones is swapped for SAFE_SEED
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm <= IDLE;
      rnd_o <= RESET_SEED;
      rnd_valid_o <= 1'b0;
      seed_fix_o <= 1'b0;
      word_cnt_o <= '0;
    end else begin
      seed_fix_o <= load_i && ones;
      if (load_i) begin
        fsm <= RUN;
        rnd_o <= ones ? SAFE_SEED : seed_i;
        rnd_valid_o <= 1'b1;
        word_cnt_o <= '0;
      end else if (fsm == RUN) begin
        if (free_run_i || rnd_ready_i) rnd_o <= nxt;
        if (rnd_ready_i) word_cnt_o <= word_cnt_o + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed and randomized checks of lfsr_gen against a parity-based model
module tb_lfsr_gen;
  import lfsr_pkg::*;
  logic clk = 0, reset = 1, load = 0, fr = 0, rdy = 0;
  logic [15:0] seed = 0;
  logic [15:0] rnd, rnd2;
  logic v, v2, fix, fix2;
  logic [31:0] cnt, cnt2;
  int checks = 0, errors = 0;
  localparam logic [15:0] EXP [5] = '{16'h0001, 16'h0003, 16'h0007, 16'h000F, 16'h001E};

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(16), .TAPS(TAPS16), .STEPS(1)) dut (
    .clk(clk), .reset(reset), .seed_i(seed), .load_i(load), .free_run_i(fr),
    .rnd_o(rnd), .rnd_valid_o(v), .rnd_ready_i(rdy), .seed_fix_o(fix), .word_cnt_o(cnt));
  lfsr_gen #(.WIDTH(16), .TAPS(TAPS16), .STEPS(2)) dut2 (
    .clk(clk), .reset(reset), .seed_i(seed), .load_i(load), .free_run_i(fr),
    .rnd_o(rnd2), .rnd_valid_o(v2), .rnd_ready_i(rdy), .seed_fix_o(fix2), .word_cnt_o(cnt2));

  function automatic logic [15:0] adv(input logic [15:0] s, input int n);
    for (int k = 0; k < n; k++) s = {s[14:0], ($countones(s & TAPS16) % 2) == 0};
    return s;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] s);
    seed = s;
    load = 1;
    cyc();
    load = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    cyc();
    checks++; if (rnd !== 16'h0000) begin errors++; $display("FAIL reset_rnd got %h want 0000", rnd); end
    checks++; if (v !== 1'b0 || fix !== 1'b0) begin errors++; $display("FAIL reset_flags got v=%b fix=%b want 0 0", v, fix); end
    checks++; if (cnt !== 0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt); end
    reset = 0;
    fr = 1; rdy = 1;
    repeat (3) cyc();
    checks++; if (rnd !== 16'h0000 || v !== 1'b0 || cnt !== 0) begin errors++; $display("FAIL idle_hold got rnd=%h v=%b cnt=%0d want 0000 0 0", rnd, v, cnt); end
    fr = 0; rdy = 0;
  endtask

  task automatic test_handshake();
    do_load(16'h0001);
    checks++; if (v !== 1'b1 || fix !== 1'b0) begin errors++; $display("FAIL load_valid got v=%b fix=%b want 1 0", v, fix); end
    rdy = 1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rnd !== EXP[i] || cnt !== 32'(i)) begin errors++; $display("FAIL seq%0d got %h cnt=%0d want %h cnt=%0d", i, rnd, cnt, EXP[i], i); end
      cyc();
    end
    rdy = 0;
  endtask

  task automatic test_steps();
    do_load(16'h0001);
    rdy = 1;
    cyc();
    checks++; if (rnd2 !== 16'h0007) begin errors++; $display("FAIL steps2_a got %h want 0007", rnd2); end
    cyc();
    checks++; if (rnd2 !== 16'h001E || cnt2 !== 2) begin errors++; $display("FAIL steps2_b got %h cnt=%0d want 001E 2", rnd2, cnt2); end
    rdy = 0;
  endtask

  task automatic test_seed_fix();
    do_load(16'hFFFF);
    checks++; if (rnd !== 16'h0000 || fix !== 1'b1) begin errors++; $display("FAIL seed_fix got rnd=%h fix=%b want 0000 1", rnd, fix); end
    cyc();
    checks++; if (fix !== 1'b0) begin errors++; $display("FAIL seed_fix_pulse got %b want 0", fix); end
  endtask

  task automatic test_hold_free();
    logic [15:0] prev;
    int bad = 0;
    fr = 0; rdy = 0;
    do_load(16'h1234);
    repeat (5) begin
      cyc();
      if (rnd !== 16'h1234 || cnt !== 0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hold got rnd=%h cnt=%0d want 1234 0", rnd, cnt); end
    fr = 1; bad = 0;
    repeat (8) begin
      prev = rnd;
      cyc();
      if (rnd === prev || rnd !== adv(prev, 1) || cnt !== 0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL free_run got %0d bad cycles want 0", bad); end
    fr = 0;
  endtask

  task automatic test_period();
    int first = 0, ones = 0;
    fr = 1; rdy = 0;
    do_load(16'h0000);
    for (int i = 1; i <= 65535; i++) begin
      cyc();
      if (rnd === 16'hFFFF) ones++;
      if (rnd === 16'h0000 && first == 0) first = i;
    end
    checks++; if (first != 65535) begin errors++; $display("FAIL period got %0d want 65535", first); end
    checks++; if (ones != 0) begin errors++; $display("FAIL lockup_seen got %0d want 0", ones); end
    fr = 0;
  endtask

  task automatic test_load_hs();
    do_load(16'h0101);
    rdy = 1;
    repeat (3) cyc();
    seed = 16'h00AA; load = 1;
    cyc();
    load = 0; rdy = 0;
    checks++; if (rnd !== 16'h00AA || cnt !== 0) begin errors++; $display("FAIL load_hs got %h cnt=%0d want 00AA 0", rnd, cnt); end
  endtask

  task automatic test_random();
    logic [15:0] ms, ms2;
    logic mfix;
    int unsigned mc;
    int bad = 0;
    do_load(16'h5A5A);
    ms = 16'h5A5A; ms2 = 16'h5A5A; mc = 0;
    for (int i = 0; i < 400; i++) begin
      load = ($urandom_range(0, 15) == 0);
      seed = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      rdy = $urandom_range(0, 1) == 1;
      fr = $urandom_range(0, 3) == 0;
      mfix = load && seed == 16'hFFFF;
      if (load) begin
        ms = mfix ? 16'h0000 : seed; ms2 = ms; mc = 0;
      end else begin
        if (fr || rdy) begin ms = adv(ms, 1); ms2 = adv(ms2, 2); end
        if (rdy) mc++;
      end
      cyc();
      if (rnd !== ms || rnd2 !== ms2 || cnt !== mc || fix !== mfix || v !== 1'b1) begin
        bad++;
        if (bad < 4) $display("FAIL random%0d got %h %h %0d %b want %h %h %0d %b", i, rnd, rnd2, cnt, fix, ms, ms2, mc, mfix);
      end
    end
    load = 0; rdy = 0; fr = 0;
    checks++; if (bad != 0) begin errors++; $display("FAIL random got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_reset_mid();
    fr = 1; rdy = 1;
    do_load(16'h0F0F);
    repeat (3) cyc();
    reset = 1;
    #1;
    checks++; if (v !== 1'b0 || rnd !== 16'h0000 || cnt !== 0 || fix !== 1'b0) begin errors++; $display("FAIL reset_mid got v=%b rnd=%h cnt=%0d want 0 0000 0", v, rnd, cnt); end
    cyc();
    reset = 0;
    fr = 0; rdy = 0;
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_steps();
    test_seed_fix();
    test_hold_free();
    test_period();
    test_load_hs();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
